// File: rtl/piso_transmitter_pkg.sv
// rtl/piso_transmitter_pkg.sv - shared shift-register FSM encodings
// Reused by sibling shift blocks so every block agrees on the state encoding.
package piso_transmitter_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } shift_state_t;

endpackage

// File: rtl/piso_transmitter.sv
// rtl/piso_transmitter.sv - parallel-in serial-out frame transmitter
// Shifts one WIDTH-bit word out per frame; bit_en paces consumption of each bit.
module piso_transmitter
  import piso_transmitter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  shift_state_t     state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             last_bit;
  logic             transfer;

  assign last_bit = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      cnt       <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    transfer   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        // Ready only on the edge that consumes the final bit, so a reload has no gap.
        in_ready = last_bit && bit_en;
        if (bit_en && !last_bit) begin
          shift_next = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
          cnt_next   = cnt + CW'(1);
        end else if (bit_en && last_bit) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    transfer = in_valid && in_ready;
    if (transfer) begin
      shift_next = in_data;
      cnt_next   = '0;
      state_next = SHIFT;
    end
  end

  assign dout_valid  = (state == SHIFT);
  assign dout        = dout_valid && (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
  assign frame_start = dout_valid && (cnt == '0);
  assign frame_last  = dout_valid && last_bit;

endmodule

// File: tb/tb_piso_transmitter.sv
// tb/tb_piso_transmitter.sv - self-checking bench for piso_transmitter
// Two instances (MSB-first and LSB-first) share stimulus and are checked against a frame-level model.
module tb_piso_transmitter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         bit_en;

  logic in_ready_m, dout_m, dout_valid_m, frame_start_m, frame_last_m;
  logic in_ready_l, dout_l, dout_valid_l, frame_start_l, frame_last_l;

  int total = 0;
  int bad   = 0;

  // Model: the word being sent and how many bits of it have already been consumed.
  logic [W-1:0] m_word;
  int           m_sent;
  bit           m_active;

  logic [W-1:0] coll_m, coll_l;
  int           valid_cnt;

  piso_transmitter #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .bit_en(bit_en), .dout(dout_m),
    .dout_valid(dout_valid_m), .frame_start(frame_start_m), .frame_last(frame_last_m)
  );

  piso_transmitter #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .bit_en(bit_en), .dout(dout_l),
    .dout_valid(dout_valid_l), .frame_start(frame_start_l), .frame_last(frame_last_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_sent   = 0;
    m_word   = '0;
  endtask

  task automatic check_outputs();
    logic exp_ready, exp_dm, exp_dl;
    exp_ready = !m_active || ((m_sent == W - 1) && bit_en);
    exp_dm    = m_active ? m_word[W-1-m_sent] : 1'b0;
    exp_dl    = m_active ? m_word[m_sent] : 1'b0;
    chk("msb_in_ready", in_ready_m, exp_ready);
    chk("lsb_in_ready", in_ready_l, exp_ready);
    chk("msb_dout", dout_m, exp_dm);
    chk("lsb_dout", dout_l, exp_dl);
    chk("msb_dout_valid", dout_valid_m, m_active);
    chk("lsb_dout_valid", dout_valid_l, m_active);
    chk("msb_frame_start", frame_start_m, m_active && (m_sent == 0));
    chk("lsb_frame_start", frame_start_l, m_active && (m_sent == 0));
    chk("msb_frame_last", frame_last_m, m_active && (m_sent == W - 1));
    chk("lsb_frame_last", frame_last_l, m_active && (m_sent == W - 1));
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic be);
    bit take;
    in_valid = v;
    in_data  = d;
    bit_en   = be;
    #1;
    check_outputs();
    coll_m = {coll_m[W-2:0], dout_m};
    coll_l = {dout_l, coll_l[W-1:1]};
    if (dout_valid_m) valid_cnt++;
    take = v && (!m_active || ((m_sent == W - 1) && be));
    @(posedge clk);
    if (take) begin
      m_word   = d;
      m_sent   = 0;
      m_active = 1'b1;
    end else if (m_active && be) begin
      if (m_sent == W - 1) m_active = 1'b0;
      else m_sent++;
    end
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    bit_en   = 1'b0;
    model_reset();
    #12;
    chk("reset_in_ready", in_ready_m, 1'b1);
    chk("reset_dout", dout_m, 1'b0);
    chk("reset_dout_valid", dout_valid_m, 1'b0);
    chk("reset_frame_start", frame_start_m, 1'b0);
    chk("reset_frame_last", frame_last_m, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single A5 frame, bit_en held high.
    cycle(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < W; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("a5_msb_bits", coll_m, 8'hA5);
    chk("a5_lsb_bits", coll_l, 8'hA5);
    cycle(1'b0, 8'h00, 1'b1);

    // Back-to-back A5 then 3C held valid until taken.
    cycle(1'b1, 8'hA5, 1'b1);
    valid_cnt = 0;
    for (int i = 0; i < W; i++) cycle(1'b1, 8'h3C, 1'b1);
    chk("b2b_first_msb", coll_m, 8'hA5);
    for (int i = 0; i < W; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("b2b_second_msb", coll_m, 8'h3C);
    chk("b2b_contiguous", valid_cnt, 16);
    cycle(1'b0, 8'h00, 1'b1);

    // LSB-first 01 frame.
    cycle(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < W; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("lsb_01_bits", coll_l, 8'h01);
    chk("msb_01_bits", coll_m, 8'h01);

    // F0 with bit_en every third cycle: 24-cycle frame.
    cycle(1'b1, 8'hF0, 1'b0);
    valid_cnt = 0;
    for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, (i % 3) == 2);
    chk("slow_frame_len", valid_cnt, 24);

    // FF offered mid-frame of 00, taken only on the frame_last edge.
    cycle(1'b1, 8'h00, 1'b1);
    for (int i = 1; i <= W; i++) cycle(i >= 4, (i >= 4) ? 8'hFF : 8'h00, 1'b1);
    chk("hold_00_bits", coll_m, 8'h00);
    for (int i = 0; i < W; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("hold_ff_bits", coll_m, 8'hFF);

    // Asynchronous reset during bit 4.
    cycle(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_dout_valid", dout_valid_m, 1'b0);
    chk("midrst_in_ready", in_ready_m, 1'b1);
    chk("midrst_frame_last", frame_last_m, 1'b0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h96, 1'b1);
    for (int i = 0; i < W; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("postrst_bits", coll_m, 8'h96);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_transmitter.md
PISO_TRANSMITTER -- requirements
Module: piso_transmitter

Interface
REQ-001 Parameter WIDTH, default 8: frame length in bits; SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
REQ-003 Port clk  input  1: clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port in_data  input  WIDTH: parallel word to serialize.
REQ-006 Port in_valid  input  1: in_data is valid.
REQ-007 Port in_ready  output  1: block can accept a word this cycle.
REQ-008 Port bit_en  input  1: bit-rate strobe; the current serial bit is consumed at an edge only where bit_en=1.
REQ-009 Port dout  output  1: serial data.
REQ-010 Port dout_valid  output  1: dout carries a frame bit.
REQ-011 Port frame_start  output  1: high while the first bit of a frame is on dout.
REQ-012 Port frame_last  output  1: high while the last bit of a frame is on dout.

Function
REQ-013 FSM states SHALL be IDLE and SHIFT.
REQ-014 Internal state SHALL be: WIDTH-bit shift register; bit counter cnt, width $clog2(WIDTH), range 0..WIDTH-1.
REQ-015 in_ready SHALL be 1 in IDLE, and 1 in SHIFT only when cnt==WIDTH-1 and bit_en=1; 0 otherwise.
REQ-016 Transfer occurs at an edge where in_valid=1 and in_ready=1: load in_data into the shift register, cnt<=0, state<=SHIFT.
REQ-017 in_valid with in_ready=0 SHALL be ignored; in_data is not sampled; upstream holds the word.
REQ-018 In SHIFT, dout SHALL be shift_reg[WIDTH-1] when MSB_FIRST=1, else shift_reg[0]; dout_valid=1.
REQ-019 In SHIFT at an edge with bit_en=1 and cnt<WIDTH-1: shift toward the output end by one bit, cnt<=cnt+1.
REQ-020 In SHIFT with bit_en=0: shift register, cnt and state SHALL hold; the bit remains on dout.
REQ-021 In SHIFT at an edge with bit_en=1 and cnt==WIDTH-1: if a transfer occurs (REQ-016), reload with no gap cycle; otherwise state<=IDLE.
REQ-022 frame_start SHALL equal (state==SHIFT && cnt==0); frame_last SHALL equal (state==SHIFT && cnt==WIDTH-1).
REQ-023 In IDLE: dout=0, dout_valid=0, frame_start=0, frame_last=0.
REQ-024 Latency: first bit SHALL appear on dout in the cycle after the transfer edge, independent of bit_en.
REQ-025 Frame duration: exactly WIDTH bit_en-qualified cycles; with bit_en held at 1, WIDTH clock cycles.
REQ-026 All outputs except in_ready SHALL be functions of registered state only; in_ready depends combinationally on bit_en.

Reset
REQ-027 rst=1 SHALL force IDLE, cnt=0 and shift register=0 immediately, regardless of clk.
REQ-028 Reset values SHALL be in_ready=1, dout=0, dout_valid=0, frame_start=0, frame_last=0.
REQ-029 Reset mid-frame SHALL abort the frame with no frame_last pulse; the first edge after release behaves as IDLE.

Structure
REQ-030 FSM state encodings (IDLE=0, SHIFT=1) SHALL be localparams in the team's shared shift-register package/include, reused by sibling shift blocks.
REQ-031 Implementation SHALL be a single module; no sub-module required; counter and FSM inline.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, bit_en=1, load 8'hA5 -> dout 1,0,1,0,0,1,0,1 over cycles 1-8; frame_start in cycle 1; frame_last in cycle 8; IDLE in cycle 9.
REQ-033 Back-to-back: 8'hA5, then 8'h3C offered continuously -> 16 contiguous dout_valid cycles; in_ready high only in cycle 8; second frame starts cycle 9 with bits 0,0,1,1,1,1,0,0.
REQ-034 MSB_FIRST=0, load 8'h01 -> dout 1 then seven 0s.
REQ-035 bit_en high every 3rd cycle, load 8'hF0 -> each bit held 3 cycles; 24-cycle frame; bit order unchanged.
REQ-036 in_valid=1 with 8'hFF during cycle 4 of an 8'h00 frame -> not accepted; 8'h00 frame completes unchanged; 8'hFF accepted at frame_last edge.
REQ-037 rst asserted during bit 4 -> dout_valid=0 and in_ready=1 immediately; no frame_last; next word transmits from bit 0.
